alu_cmd_issuer: RTL and testbench

// - Initiator side of the ALU start/done interface. It buffers operand/op commands from a

---
 rtl/alu_if_pkg.sv | 23 ++
 rtl/alu_cmd_issuer_if.sv | 38 +++
 rtl/alu_cmd_fifo.sv | 54 +++++
 rtl/alu_cmd_issuer.sv | 103 ++++++++++
 tb/tb_alu_cmd_issuer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_if_pkg.sv
// Shared types for the ALU start/done command path: op codes, FSM states and the
// command payload carried through the issuer FIFO.
package alu_if_pkg;

    localparam int unsigned ALU_W = 16;
    localparam int unsigned OP_W  = 3;

    localparam logic [OP_W-1:0] ALU_OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] ALU_OP_SUB = 3'b001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } issuer_state_t;

    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [OP_W-1:0]  op;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU and response signals of the issuer; master is the issuer side,
// slave is the sequencer/ALU/consumer side.
interface alu_cmd_issuer_if #(
    parameter int unsigned W = 16
);
    import alu_if_pkg::*;

    logic            cmd_valid;
    logic            cmd_ready;
    logic [W-1:0]    cmd_a;
    logic [W-1:0]    cmd_b;
    logic [OP_W-1:0] cmd_op;

    logic [W-1:0]    alu_a;
    logic [W-1:0]    alu_b;
    logic [OP_W-1:0] alu_op;
    logic            alu_start;
    logic            alu_done;
    logic [W-1:0]    alu_result;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [W-1:0]    rsp_data;
    logic            rsp_err;

    logic            busy;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_done, alu_result, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_op, alu_start, rsp_valid, rsp_data, rsp_err, busy
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_op, alu_done, alu_result, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_op, alu_start, rsp_valid, rsp_data, rsp_err, busy
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with async reset; head entry is presented combinationally.
module alu_cmd_fifo
    import alu_if_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  alu_cmd_t wdata,
    output alu_cmd_t rdata,
    output logic     full,
    output logic     empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    alu_cmd_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Buffers sequencer commands and issues them one at a time to the ALU over start/done,
// returning each result (or a timeout error) on a valid/ready response port.
module alu_cmd_issuer
    import alu_if_pkg::*;
#(
    parameter int unsigned W       = ALU_W,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    alu_cmd_issuer_if.master  bus
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    issuer_state_t   state;
    logic [TO_W-1:0] to_cnt;
    logic [W-1:0]    alu_a_q;
    logic [W-1:0]    alu_b_q;
    logic [OP_W-1:0] alu_op_q;
    logic            rsp_valid_q;
    logic [W-1:0]    rsp_data_q;
    logic            rsp_err_q;

    alu_cmd_t        push_cmd;
    alu_cmd_t        head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;

    assign push_cmd = '{a: ALU_W'(bus.cmd_a), b: ALU_W'(bus.cmd_b), op: bus.cmd_op};
    assign push     = bus.cmd_valid && !fifo_full;
    // Issue only when the response slot is free or being drained this cycle.
    assign pop      = (state == IDLE) && !fifo_empty && (!rsp_valid_q || bus.rsp_ready);

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (push_cmd),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            to_cnt      <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (rsp_valid_q && bus.rsp_ready) rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        alu_a_q  <= W'(head.a);
                        alu_b_q  <= W'(head.b);
                        alu_op_q <= head.op;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    to_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    if (bus.alu_done) begin
                        rsp_data_q  <= bus.alu_result;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= IDLE;
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = !fifo_full;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_start = (state == ISSUE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer: expected responses queued at command accept,
// popped and compared by an independent response monitor.
module tb_alu_cmd_issuer;
    import alu_if_pkg::*;

    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_cmd_issuer_if #(.W(W)) bus ();

    alu_cmd_issuer #(.W(W), .DEPTH(4), .TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   vec_cnt   = 0;
    int   miss_cnt  = 0;
    int   rsp_cnt   = 0;
    int   start_cnt = 0;
    exp_t exp_q[$];

    logic         stall     = 1'b0;
    int           max_lat   = 0;
    logic         model_done = 1'b0;
    logic         inj_done  = 1'b0;
    logic [W-1:0] model_result = '0;
    logic         rdy_fixed = 1'b1;
    logic         rnd_rdy   = 1'b0;

    assign bus.alu_done   = model_done | inj_done;
    assign bus.alu_result = model_result;

    function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] op);
        return (op == ALU_OP_SUB) ? W'(a - b) : W'(a + b);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural ALU: answers lat+1 cycles after start, never in stall mode.
    logic         pend = 1'b0;
    int           dly  = 0;
    logic [W-1:0] ma, mb;
    logic [2:0]   mop;
    always @(posedge clk or posedge rst) begin
        int l;
        if (rst) begin
            model_done <= 1'b0;
            pend       <= 1'b0;
        end else begin
            model_done <= 1'b0;
            if (bus.alu_start && !stall) begin
                l = $urandom_range(0, max_lat);
                if (l == 0) begin
                    model_done   <= 1'b1;
                    model_result <= alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);
                end else begin
                    pend <= 1'b1;
                    dly  <= l;
                    ma   <= bus.alu_a;
                    mb   <= bus.alu_b;
                    mop  <= bus.alu_op;
                end
            end else if (pend) begin
                if (dly == 1) begin
                    model_done   <= 1'b1;
                    model_result <= alu_ref(ma, mb, mop);
                    pend         <= 1'b0;
                end
                dly <= dly - 1;
            end
        end
    end

    // Consumer ready, changed mid-cycle away from the other drivers.
    always @(posedge clk) begin
        #2;
        bus.rsp_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    // Response monitor: scoreboard pop plus hold-while-stalled check.
    exp_t         e;
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_data = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (bus.alu_start) start_cnt++;
            if (prev_hold) begin
                check("rsp_hold_valid", 32'(bus.rsp_valid), 32'd1);
                check("rsp_hold_data", 32'(bus.rsp_data), 32'(prev_data));
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_cnt++;
                if (exp_q.size() == 0) begin
                    vec_cnt++;
                    miss_cnt++;
                    $display("FAIL unexpected_rsp: got data 0x%0h err %0b, expected none", bus.rsp_data, bus.rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                    check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                end
            end
            prev_hold = bus.rsp_valid && !bus.rsp_ready;
            prev_data = bus.rsp_data;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        exp_t x;
        int   n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_op    = op;
        forever begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                x.data = stall ? '0 : alu_ref(a, b, op);
                x.err  = stall;
                exp_q.push_back(x);
                break;
            end
            n++;
            if (n > 500) begin
                vec_cnt++;
                miss_cnt++;
                $display("FAIL cmd_accept_timeout: got no cmd_ready in %0d cycles, expected accept", n);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input int exp_cyc);
        int k;
        k = 0;
        while (!bus.rsp_valid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, 32'(k), 32'(exp_cyc));
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (exp_q.size() != 0) begin
            vec_cnt++;
            miss_cnt++;
            $display("FAIL drain_timeout: got %0d pending responses, expected 0", exp_q.size());
        end
    endtask

    initial begin
        int base_s, base_r;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_op    = '0;
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(1);

        check("rst_alu_a", 32'(bus.alu_a), 32'd0);
        check("rst_alu_b", 32'(bus.alu_b), 32'd0);
        check("rst_alu_op", 32'(bus.alu_op), 32'd0);
        check("rst_alu_start", 32'(bus.alu_start), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Single add with latency measurement.
        base_s = start_cnt;
        send(16'h1234, 16'h0FF0, ALU_OP_ADD);
        wait_rsp("add_latency", 3);
        wait_drain();
        check("add_start_pulses", 32'(start_cnt - base_s), 32'd1);

        send(16'h0005, 16'h0007, ALU_OP_SUB);
        wait_drain();

        // Backpressure fills the FIFO behind one held response.
        rdy_fixed = 1'b0;
        cycles(2);
        base_s = start_cnt;
        base_r = rsp_cnt;
        for (int i = 1; i <= 5; i++) send(W'(i), 16'h0001, ALU_OP_ADD);
        check("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        cycles(5);
        check("full_one_start", 32'(start_cnt - base_s), 32'd1);
        check("full_rsp_held", 32'(bus.rsp_valid), 32'd1);
        check("full_busy", 32'(bus.busy), 32'd1);
        rdy_fixed = 1'b1;
        wait_drain();
        check("full_starts", 32'(start_cnt - base_s), 32'd5);
        check("full_rsps", 32'(rsp_cnt - base_r), 32'd5);

        // Hung ALU: timeout error, then a late done must be ignored.
        stall  = 1'b1;
        base_r = rsp_cnt;
        send(16'hAAAA, 16'h5555, ALU_OP_ADD);
        wait_rsp("timeout_latency", 17);
        cycles(2);
        inj_done = 1'b1;
        cycles(1);
        inj_done = 1'b0;
        cycles(5);
        check("late_done_rsps", 32'(rsp_cnt - base_r), 32'd1);
        check("late_done_valid", 32'(bus.rsp_valid), 32'd0);
        check("late_done_busy", 32'(bus.busy), 32'd0);

        // Reset while waiting with commands queued.
        base_r = rsp_cnt;
        send(16'h0010, 16'h0001, ALU_OP_ADD);
        send(16'h0020, 16'h0002, ALU_OP_SUB);
        send(16'h0030, 16'h0003, ALU_OP_ADD);
        cycles(3);
        rst = 1'b1;
        exp_q.delete();
        cycles(2);
        rst = 1'b0;
        stall = 1'b0;
        inj_done = 1'b1;
        cycles(1);
        inj_done = 1'b0;
        cycles(3);
        check("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("mid_rst_rsps", 32'(rsp_cnt - base_r), 32'd0);
        send(16'h0001, 16'h0001, ALU_OP_ADD);
        wait_rsp("post_rst_latency", 3);
        wait_drain();
        check("post_rst_rsps", 32'(rsp_cnt - base_r), 32'd1);

        // Randomized traffic with variable ALU latency and random consumer ready.
        max_lat = 3;
        rnd_rdy = 1'b1;
        base_r  = rsp_cnt;
        for (int i = 0; i < 40; i++) begin
            send(W'($urandom), W'($urandom), ($urandom_range(0, 1) == 1) ? ALU_OP_SUB : ALU_OP_ADD);
            if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 4));
        end
        wait_drain();
        rnd_rdy = 1'b0;
        cycles(3);
        check("rnd_rsps", 32'(rsp_cnt - base_r), 32'd40);
        check("final_busy", 32'(bus.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

endmodule
